// File: rtl/dct_block_sink.sv
// dct_block_sink: captures one 64-sample DCT output burst, then drains it in
// JPEG zigzag order over a valid/ready handshake. Each output word is a
// sign-extended coefficient field cut out of the captured input word.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   done, din       - burst strobe and sample word from the DCT core
//   out_valid/ready - output handshake
//   out_data        - sign-extended coefficient field
//   out_index       - raster position (row*8+col) of out_data
//   out_last        - marks the 64th drained word
//   overflow        - sticky: a burst began while a block was draining
//   short_err       - sticky: a burst ended before 64 samples
//   state_out       - current FSM state
//
// The edge that writes the 64th sample cannot know whether done will stay
// high, so it always enters HOLD. HOLD drops any surplus samples and starts
// the drain on the first cycle that done is low, so out_valid rises one cycle
// after done falls.
module dct_block_sink #(
  parameter int unsigned BitWidth   = 31,
  parameter int unsigned FieldLsb   = 18,
  parameter int unsigned FieldWidth = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [BitWidth:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BitWidth:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              overflow,
  output logic              short_err,
  output logic [1:0]        state_out
);

  localparam int unsigned DataW = BitWidth + 1;
  localparam int unsigned Depth = 64;
  localparam int unsigned PtrW  = 6;
  localparam int unsigned CntW  = 7;
  localparam int unsigned ExtW  = DataW - FieldWidth;

  // Zigzag scan: drain step -> raster position.
  localparam logic [PtrW-1:0] ZZ [Depth] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [PtrW-1:0]     out_index_q, out_index_d;
  logic [DataW-1:0]    out_data_q, out_data_d;
  logic                overflow_q, overflow_d;
  logic                short_err_q, short_err_d;
  logic                done_prev_q, done_prev_d;

  logic                buf_we_c;
  logic [PtrW-1:0]     buf_waddr_c;
  logic                load_out_c;
  logic [PtrW-1:0]     rd_addr_c;
  logic [DataW-1:0]    rd_word_c;
  logic [FieldWidth-1:0] field_c;
  logic                rd_word_unused_c;

  logic [DataW-1:0]    buffer_q [Depth];

  // Capture buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we_c) begin
      buffer_q[buf_waddr_c] <= din;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      short_err_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      short_err_q <= short_err_d;
      done_prev_q <= done_prev_d;
    end
  end

  // Next-state, write control and drain pointer.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    short_err_d = short_err_q;
    done_prev_d = done;
    buf_we_c    = 1'b0;
    buf_waddr_c = wr_cnt_q[PtrW-1:0];
    load_out_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a fresh rising done starts a capture; a burst that was
        // already running when the drain finished is not picked up.
        if (done && !done_prev_q) begin
          buf_we_c    = !reset;
          buf_waddr_c = '0;
          wr_cnt_d    = CntW'(1);
          state_d     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (done) begin
          buf_we_c = !reset;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == CntW'(Depth - 1)) begin
            state_d = ST_HOLD;
          end
        end else begin
          short_err_d = 1'b1;
          wr_cnt_d    = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!done) begin
          state_d     = ST_DRAIN;
          wr_cnt_d    = '0;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          load_out_c  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (done && !done_prev_q) begin
          overflow_d = 1'b1;
        end
        // out_valid is always high in DRAIN, so out_ready is the handshake.
        if (out_ready) begin
          if (rd_ptr_q == PtrW'(Depth - 1)) begin
            state_d     = ST_IDLE;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            out_last_d = (rd_ptr_q == PtrW'(Depth - 2));
            load_out_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output word load: zigzag lookup and field sign extension.
  always_comb begin
    rd_addr_c   = ZZ[rd_ptr_d];
    rd_word_c   = buffer_q[rd_addr_c];
    field_c     = rd_word_c[FieldLsb +: FieldWidth];
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    if (load_out_c) begin
      out_index_d = rd_addr_c;
      out_data_d  = {{ExtW{field_c[FieldWidth-1]}}, field_c};
    end
  end

  // Bits outside the coefficient field are stored but never presented.
  assign rd_word_unused_c = ^rd_word_c;

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign short_err = short_err_q;
  assign state_out = state_q;

endmodule
